// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory access sequencer.
// Holds RV32I load/store funct3 codes, FSM state enum and access size.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    BEAT0,
    WAIT0,
    BEAT1,
    WAIT1,
    DONE,
    ERR
  } dmem_state_e;

  // Access size in bytes: 1, 2 or 4.
  function automatic logic [2:0] acc_bytes(
    input logic [2:0] funct3
  );
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// MEM-stage request/response and data-RAM beat bus.
// slave = access controller, master = MEM stage plus RAM side.
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output mem_req, mem_we, mem_addr,
    output mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  mem_req, mem_we, mem_addr,
    input  mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables, write shifts, split detect.
// Ports: funct3/off/wdata/rdata0/rdata1 in; be0/be1/wdata0/wdata1/split/ld_data out.
module lsu_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata0,
  input  logic [31:0] rdata1,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic        split,
  output logic [31:0] ld_data
);

  logic [2:0]  n;
  logic [3:0]  mask;
  logic [7:0]  be_w;
  logic [63:0] wd_w;
  logic [63:0] rd_w;
  logic [31:0] m;

  // Shifting into a double-width word gives both beats at once:
  // the low half is beat 0, the spill-over high half is beat 1.
  always_comb begin
    n    = acc_bytes(funct3);
    mask = (n == 3'd1) ? 4'h1 :
           (n == 3'd2) ? 4'h3 : 4'hF;
    be_w = {4'h0, mask} << off;
    wd_w = {32'h0, wdata} << {off, 3'b000};
    rd_w = {rdata1, rdata0} >> {off, 3'b000};
    m    = rd_w[31:0];
    case (funct3)
      F3_B:    ld_data = {{24{m[7]}}, m[7:0]};
      F3_H:    ld_data = {{16{m[15]}}, m[15:0]};
      F3_BU:   ld_data = {24'h0, m[7:0]};
      F3_HU:   ld_data = {16'h0, m[15:0]};
      default: ld_data = m;
    endcase
  end

  assign be0    = be_w[3:0];
  assign be1    = be_w[7:4];
  assign wdata0 = wd_w[31:0];
  assign wdata1 = wd_w[63:32];
  assign split  = |be_w[7:4];

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: one load/store per handshake, split in
// up to two aligned beats. Ports: clk, n_rst (active high), bus (slave).
module dmem_access_ctrl
  import mem_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter int ADDR_W           = 32
) (
  input logic             clk,
  input logic             n_rst,
  dmem_access_ctrl_if.slave bus
);

  dmem_state_e state_q, state_d;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata0_q;
  logic [31:0]       rdata1_q;

  logic              idle, accept;
  logic              a_we;
  logic [2:0]        a_f3;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_wdata;
  logic [ADDR_W-1:0] word0;
  logic [31:0]       rd0, rd1, ld_data;
  logic [31:0]       wdata0, wdata1;
  logic [3:0]        be0, be1;
  logic              split, legal, bad;

  logic              req_d;
  logic [3:0]        be_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wd_d;

  assign idle          = (state_q == IDLE);
  assign bus.req_ready = idle && !n_rst;
  assign accept        = bus.req_valid && bus.req_ready;

  // In IDLE the first beat is built straight from the request so it
  // can be registered on the accept edge.
  assign a_we    = idle ? bus.req_we     : we_q;
  assign a_f3    = idle ? bus.req_funct3 : f3_q;
  assign a_addr  = idle ? bus.req_addr   : addr_q;
  assign a_wdata = idle ? bus.req_wdata  : wdata_q;
  assign word0   = {a_addr[ADDR_W-1:2], 2'b00};

  // Feed the arriving word through so DONE sees the final result.
  assign rd0 = (state_q == WAIT0) ? bus.mem_rdata : rdata0_q;
  assign rd1 = (state_q == WAIT1) ? bus.mem_rdata : rdata1_q;

  lsu_lane_align u_align (
    .funct3  (a_f3),
    .off     (a_addr[1:0]),
    .wdata   (a_wdata),
    .rdata0  (rd0),
    .rdata1  (rd1),
    .be0     (be0),
    .be1     (be1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .split   (split),
    .ld_data (ld_data)
  );

  assign legal = (a_f3 == F3_B) || (a_f3 == F3_H) ||
                 (a_f3 == F3_W) ||
                 (!a_we && ((a_f3 == F3_BU) ||
                            (a_f3 == F3_HU)));
  assign bad   = !legal || (!ALLOW_MISALIGNED && split);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (accept) state_d = bad ? ERR : BEAT0;
      BEAT0:
        if (bus.mem_gnt)
          state_d = !we_q ? WAIT0 :
                    split ? BEAT1 : DONE;
      WAIT0:
        if (bus.mem_rvalid)
          state_d = split ? BEAT1 : DONE;
      BEAT1:
        if (bus.mem_gnt)
          state_d = we_q ? DONE : WAIT1;
      WAIT1:
        if (bus.mem_rvalid) state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next beat; recomputed every cycle but stable while waiting for
  // a grant since it only depends on captured request fields.
  always_comb begin
    req_d  = 1'b0;
    be_d   = '0;
    addr_d = '0;
    wd_d   = '0;
    if (state_d == BEAT0) begin
      req_d  = 1'b1;
      be_d   = be0;
      addr_d = word0;
      wd_d   = a_we ? wdata0 : '0;
    end else if (state_d == BEAT1) begin
      req_d  = 1'b1;
      be_d   = be1;
      addr_d = word0 + ADDR_W'(4);
      wd_d   = a_we ? wdata1 : '0;
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      f3_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= bus.req_we;
        f3_q     <= bus.req_funct3;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        rdata0_q <= '0;
        rdata1_q <= '0;
      end
      if (state_q == WAIT0 && bus.mem_rvalid)
        rdata0_q <= bus.mem_rdata;
      if (state_q == WAIT1 && bus.mem_rvalid)
        rdata1_q <= bus.mem_rdata;
      bus.rsp_valid <= (state_d == DONE) ||
                       (state_d == ERR);
      bus.rsp_err   <= (state_d == ERR);
      if (state_d == DONE)
        bus.rsp_rdata <= we_q ? '0 : ld_data;
      else if (state_d == ERR)
        bus.rsp_rdata <= '0;
      bus.mem_req   <= req_d;
      bus.mem_we    <= req_d && a_we;
      bus.mem_be    <= be_d;
      bus.mem_addr  <= addr_d;
      bus.mem_wdata <= wd_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: stores, loads, splits, errors,
// grant stalls, reset abort and back-to-back requests.
module tb_dmem_access_ctrl;
  import mem_pkg::*;

  logic clk;
  logic n_rst;

  dmem_access_ctrl_if #(.ADDR_W(32)) u_if ();
  dmem_access_ctrl_if #(.ADDR_W(32)) u_if2 ();

  dmem_access_ctrl #(
    .ALLOW_MISALIGNED(1'b1),
    .ADDR_W(32)
  ) u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (u_if.slave)
  );

  dmem_access_ctrl #(
    .ALLOW_MISALIGNED(1'b0),
    .ADDR_W(32)
  ) u_dut2 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (u_if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int fails;

  int          nb;
  logic [31:0] b_addr [2];
  logic [3:0]  b_be   [2];
  logic [31:0] b_wd   [2];
  logic        b_we   [2];
  int          lat;
  logic [31:0] r_data;
  logic        r_err;
  logic        got;
  logic        stable_ok;
  logic        ready0;

  task automatic idle_inputs();
    u_if.req_valid   = 1'b0;
    u_if.req_we      = 1'b0;
    u_if.req_funct3  = 3'b000;
    u_if.req_addr    = '0;
    u_if.req_wdata   = '0;
    u_if.mem_gnt     = 1'b0;
    u_if.mem_rvalid  = 1'b0;
    u_if.mem_rdata   = 32'hBAD0BAD0;
    u_if2.req_valid  = 1'b0;
    u_if2.req_we     = 1'b0;
    u_if2.req_funct3 = 3'b000;
    u_if2.req_addr   = '0;
    u_if2.req_wdata  = '0;
    u_if2.mem_gnt    = 1'b0;
    u_if2.mem_rvalid = 1'b0;
    u_if2.mem_rdata  = 32'hBAD0BAD0;
  endtask

  // Drives one request into u_dut and acts as the RAM: grants each
  // beat after gw wait cycles, returns read data one cycle after grant.
  task automatic xact(
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] wd,
    input int          gw,
    input logic [31:0] rd0,
    input logic [31:0] rd1
  );
    int   waited;
    logic pend_rd;
    nb = 0; lat = -1; got = 1'b0;
    stable_ok = 1'b1; r_data = 'x; r_err = 'x;
    waited = 0; pend_rd = 1'b0;
    @(negedge clk);
    ready0          = u_if.req_ready;
    u_if.req_valid  = 1'b1;
    u_if.req_we     = we;
    u_if.req_funct3 = f3;
    u_if.req_addr   = a;
    u_if.req_wdata  = wd;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      u_if.req_valid  = 1'b0;
      u_if.mem_gnt    = 1'b0;
      u_if.mem_rvalid = 1'b0;
      u_if.mem_rdata  = 32'hBAD0BAD0;
      if (pend_rd) begin
        u_if.mem_rvalid = 1'b1;
        u_if.mem_rdata  = (nb == 1) ? rd0 : rd1;
        pend_rd = 1'b0;
      end
      if (u_if.rsp_valid) begin
        lat = cyc; got = 1'b1;
        r_data = u_if.rsp_rdata;
        r_err  = u_if.rsp_err;
        break;
      end
      if (u_if.mem_req && nb < 2) begin
        if (waited == 0) begin
          b_addr[nb] = u_if.mem_addr;
          b_be[nb]   = u_if.mem_be;
          b_wd[nb]   = u_if.mem_wdata;
          b_we[nb]   = u_if.mem_we;
        end else if (b_addr[nb] !== u_if.mem_addr ||
                     b_be[nb]   !== u_if.mem_be   ||
                     b_wd[nb]   !== u_if.mem_wdata ||
                     b_we[nb]   !== u_if.mem_we) begin
          stable_ok = 1'b0;
        end
        if (waited >= gw) begin
          u_if.mem_gnt = 1'b1;
          pend_rd = !u_if.mem_we;
          waited = 0;
          nb++;
        end else begin
          waited++;
        end
      end else if (u_if.mem_req) begin
        nb++;
      end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (u_if.req_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_ready got=%b exp=0", u_if.req_ready);
    end
    tests_run++;
    if ({u_if.rsp_valid, u_if.rsp_err, u_if.mem_req,
         u_if.mem_we} !== 4'b0) begin
      fails++;
      $display("FAIL rst_flags got=%b exp=0000",
        {u_if.rsp_valid, u_if.rsp_err, u_if.mem_req, u_if.mem_we});
    end
    tests_run++;
    if ({u_if.rsp_rdata, u_if.mem_addr, u_if.mem_wdata,
         u_if.mem_be} !== 100'h0) begin
      fails++;
      $display("FAIL rst_data got=%h/%h/%h/%h exp=0",
        u_if.rsp_rdata, u_if.mem_addr, u_if.mem_wdata, u_if.mem_be);
    end
    n_rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (u_if.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_release_ready got=%b exp=1", u_if.req_ready);
    end
  endtask

  task automatic test_sw_aligned();
    xact(1'b1, F3_W, 32'h100, 32'hDEADBEEF, 0, 0, 0);
    tests_run++;
    if (ready0 !== 1'b1) begin
      fails++;
      $display("FAIL sw_ready got=%b exp=1", ready0);
    end
    tests_run++;
    if ({got, lat[3:0], r_err, r_data} !== {1'b1, 4'd2, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL sw_rsp got=%b/%0d/%b/%h exp=1/2/0/0",
        got, lat, r_err, r_data);
    end
    tests_run++;
    if ({nb[1:0], b_addr[0], b_be[0], b_wd[0], b_we[0]} !==
        {2'd1, 32'h100, 4'hF, 32'hDEADBEEF, 1'b1}) begin
      fails++;
      $display("FAIL sw_beat got=%0d/%h/%h/%h/%b exp=1/100/f/deadbeef/1",
        nb, b_addr[0], b_be[0], b_wd[0], b_we[0]);
    end
  endtask

  task automatic test_sb();
    xact(1'b1, F3_B, 32'h203, 32'h000000A5, 0, 0, 0);
    tests_run++;
    if ({nb[1:0], b_addr[0], b_be[0], b_wd[0]} !==
        {2'd1, 32'h200, 4'b1000, 32'hA5000000}) begin
      fails++;
      $display("FAIL sb_beat got=%0d/%h/%b/%h exp=1/200/1000/a5000000",
        nb, b_addr[0], b_be[0], b_wd[0]);
    end
    tests_run++;
    if ({got, lat[3:0]} !== {1'b1, 4'd2}) begin
      fails++;
      $display("FAIL sb_lat got=%b/%0d exp=1/2", got, lat);
    end
  endtask

  task automatic test_lb_lbu();
    xact(1'b0, F3_B, 32'h101, 0, 0, 32'h000080FF, 0);
    tests_run++;
    if ({got, lat[3:0], r_err, r_data} !==
        {1'b1, 4'd3, 1'b0, 32'hFFFFFF80}) begin
      fails++;
      $display("FAIL lb_rsp got=%b/%0d/%b/%h exp=1/3/0/ffffff80",
        got, lat, r_err, r_data);
    end
    tests_run++;
    if ({b_addr[0], b_be[0], b_we[0]} !== {32'h100, 4'b0010, 1'b0}) begin
      fails++;
      $display("FAIL lb_beat got=%h/%b/%b exp=100/0010/0",
        b_addr[0], b_be[0], b_we[0]);
    end
    xact(1'b0, F3_BU, 32'h101, 0, 0, 32'h000080FF, 0);
    tests_run++;
    if ({got, r_data} !== {1'b1, 32'h00000080}) begin
      fails++;
      $display("FAIL lbu_rsp got=%b/%h exp=1/00000080", got, r_data);
    end
  endtask

  task automatic test_lw_split();
    xact(1'b0, F3_W, 32'h102, 0, 0, 32'h33445566, 32'h77881122);
    tests_run++;
    if ({nb[1:0], b_addr[0], b_be[0], b_addr[1], b_be[1]} !==
        {2'd2, 32'h100, 4'hC, 32'h104, 4'h3}) begin
      fails++;
      $display("FAIL lw_split_beats got=%0d/%h/%h/%h/%h exp=2/100/c/104/3",
        nb, b_addr[0], b_be[0], b_addr[1], b_be[1]);
    end
    tests_run++;
    if ({got, lat[3:0], r_err, r_data} !==
        {1'b1, 4'd5, 1'b0, 32'h11223344}) begin
      fails++;
      $display("FAIL lw_split_rsp got=%b/%0d/%b/%h exp=1/5/0/11223344",
        got, lat, r_err, r_data);
    end
  endtask

  task automatic test_sh_split();
    xact(1'b1, F3_H, 32'h0FF, 32'h0000BBAA, 0, 0, 0);
    tests_run++;
    if ({nb[1:0], b_addr[0], b_be[0], b_wd[0]} !==
        {2'd2, 32'h0FC, 4'h8, 32'hAA000000}) begin
      fails++;
      $display("FAIL sh_beat0 got=%0d/%h/%h/%h exp=2/0fc/8/aa000000",
        nb, b_addr[0], b_be[0], b_wd[0]);
    end
    tests_run++;
    if ({b_addr[1], b_be[1], b_wd[1]} !==
        {32'h100, 4'h1, 32'h000000BB}) begin
      fails++;
      $display("FAIL sh_beat1 got=%h/%h/%h exp=100/1/000000bb",
        b_addr[1], b_be[1], b_wd[1]);
    end
    tests_run++;
    if ({got, lat[3:0], r_err} !== {1'b1, 4'd3, 1'b0}) begin
      fails++;
      $display("FAIL sh_rsp got=%b/%0d/%b exp=1/3/0", got, lat, r_err);
    end
  endtask

  task automatic test_illegal();
    xact(1'b1, 3'b100, 32'h100, 32'h1, 0, 0, 0);
    tests_run++;
    if ({got, lat[3:0], r_err, r_data, nb[1:0]} !==
        {1'b1, 4'd1, 1'b1, 32'h0, 2'd0}) begin
      fails++;
      $display("FAIL illegal_store got=%b/%0d/%b/%h/%0d exp=1/1/1/0/0",
        got, lat, r_err, r_data, nb);
    end
    xact(1'b0, 3'b011, 32'h100, 0, 0, 0, 0);
    tests_run++;
    if ({got, lat[3:0], r_err, nb[1:0]} !== {1'b1, 4'd1, 1'b1, 2'd0}) begin
      fails++;
      $display("FAIL illegal_load got=%b/%0d/%b/%0d exp=1/1/1/0",
        got, lat, r_err, nb);
    end
  endtask

  task automatic test_no_misalign();
    @(negedge clk);
    tests_run++;
    if (u_if2.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL nomis_ready got=%b exp=1", u_if2.req_ready);
    end
    u_if2.req_valid  = 1'b1;
    u_if2.req_we     = 1'b0;
    u_if2.req_funct3 = F3_W;
    u_if2.req_addr   = 32'h102;
    @(negedge clk);
    u_if2.req_valid = 1'b0;
    tests_run++;
    if ({u_if2.rsp_valid, u_if2.rsp_err, u_if2.mem_req} !== 3'b110) begin
      fails++;
      $display("FAIL nomis_err got=%b exp=110",
        {u_if2.rsp_valid, u_if2.rsp_err, u_if2.mem_req});
    end
    @(negedge clk);
    u_if2.req_valid  = 1'b1;
    u_if2.req_we     = 1'b1;
    u_if2.req_funct3 = F3_W;
    u_if2.req_addr   = 32'h104;
    u_if2.req_wdata  = 32'hCAFEF00D;
    @(negedge clk);
    u_if2.req_valid = 1'b0;
    tests_run++;
    if ({u_if2.mem_req, u_if2.mem_be, u_if2.mem_addr, u_if2.rsp_valid} !==
        {1'b1, 4'hF, 32'h104, 1'b0}) begin
      fails++;
      $display("FAIL nomis_aligned got=%b/%h/%h/%b exp=1/f/104/0",
        u_if2.mem_req, u_if2.mem_be, u_if2.mem_addr, u_if2.rsp_valid);
    end
    u_if2.mem_gnt = 1'b1;
    @(negedge clk);
    u_if2.mem_gnt = 1'b0;
    tests_run++;
    if ({u_if2.rsp_valid, u_if2.rsp_err} !== 2'b10) begin
      fails++;
      $display("FAIL nomis_done got=%b exp=10",
        {u_if2.rsp_valid, u_if2.rsp_err});
    end
  endtask

  task automatic test_gnt_stall();
    xact(1'b1, F3_W, 32'h40, 32'h12345678, 3, 0, 0);
    tests_run++;
    if ({stable_ok, nb[1:0], b_addr[0], b_be[0], b_wd[0]} !==
        {1'b1, 2'd1, 32'h40, 4'hF, 32'h12345678}) begin
      fails++;
      $display("FAIL stall_stable got=%b/%0d/%h/%h/%h exp=1/1/40/f/12345678",
        stable_ok, nb, b_addr[0], b_be[0], b_wd[0]);
    end
    tests_run++;
    if ({got, lat[3:0]} !== {1'b1, 4'd5}) begin
      fails++;
      $display("FAIL stall_lat got=%b/%0d exp=1/5", got, lat);
    end
    xact(1'b0, F3_HU, 32'h0FF, 0, 2, 32'h99000000, 32'h000000F1);
    tests_run++;
    if ({stable_ok, got, lat[3:0], r_data} !==
        {1'b1, 1'b1, 4'd9, 32'h0000F199}) begin
      fails++;
      $display("FAIL stall_lhu got=%b/%b/%0d/%h exp=1/1/9/0000f199",
        stable_ok, got, lat, r_data);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(negedge clk);
    u_if.req_valid  = 1'b1;
    u_if.req_we     = 1'b0;
    u_if.req_funct3 = F3_W;
    u_if.req_addr   = 32'h80;
    @(negedge clk);
    u_if.req_valid = 1'b0;
    u_if.mem_gnt   = u_if.mem_req;
    @(negedge clk);
    u_if.mem_gnt = 1'b0;
    n_rst = 1'b1;
    #1;
    tests_run++;
    if ({u_if.mem_req, u_if.req_ready, u_if.rsp_valid,
         u_if.rsp_rdata} !== {3'b000, 32'h0}) begin
      fails++;
      $display("FAIL midrst_clear got=%b/%b/%b/%h exp=0/0/0/0",
        u_if.mem_req, u_if.req_ready, u_if.rsp_valid, u_if.rsp_rdata);
    end
    @(negedge clk);
    n_rst = 1'b0;
    u_if.mem_rvalid = 1'b1;
    u_if.mem_rdata  = 32'h11111111;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      u_if.mem_rvalid = 1'b0;
      if (u_if.rsp_valid || u_if.mem_req) seen = 1'b1;
    end
    tests_run++;
    if ({seen, u_if.req_ready, u_if.rsp_rdata} !== {2'b01, 32'h0}) begin
      fails++;
      $display("FAIL midrst_late got=%b/%b/%h exp=0/1/0",
        seen, u_if.req_ready, u_if.rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    xact(1'b1, F3_W, 32'h300, 32'hA5A5A5A5, 0, 0, 0);
    xact(1'b0, F3_H, 32'h102, 0, 0, 32'h80010000, 0);
    tests_run++;
    if ({ready0, got, lat[3:0], r_data} !==
        {1'b1, 1'b1, 4'd3, 32'hFFFF8001}) begin
      fails++;
      $display("FAIL b2b_lh got=%b/%b/%0d/%h exp=1/1/3/ffff8001",
        ready0, got, lat, r_data);
    end
    @(negedge clk);
    tests_run++;
    if ({u_if.rsp_valid, u_if.req_ready, u_if.rsp_rdata} !==
        {2'b01, 32'hFFFF8001}) begin
      fails++;
      $display("FAIL b2b_pulse got=%b/%b/%h exp=0/1/ffff8001",
        u_if.rsp_valid, u_if.req_ready, u_if.rsp_rdata);
    end
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    test_reset();
    test_sw_aligned();
    test_sb();
    test_lb_lbu();
    test_lw_split();
    test_sh_split();
    test_illegal();
    test_no_misalign();
    test_gnt_stall();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
